// File: rtl/logic_reset_sequencer.sv
// logic_reset_sequencer: multi-source reset controller for one clock domain.
// Synchronizes active-low reset requests, adds a synchronous soft reset,
// enforces a minimum request-free hold time, then releases the reset domains
// one at a time (bit 0 first) with a fixed spacing between releases.
// Optional build macro LOGIC_RESET_SEQUENCER_COUNTER_EN adds a saturating
// 16-bit count of returns to HOLD from RELEASE or RUN (output reset_count).
module logic_reset_sequencer #(
    parameter int RESETS      = 1,
    parameter int OUTPUTS     = 4,
    parameter int STAGES      = 2,
    parameter int HOLD_CYCLES = 16,
    parameter int STEP_CYCLES = 4
) (
    input  logic               aclk,
    input  logic               areset,
    input  logic [RESETS-1:0]  reset_request_n,
    input  logic               soft_reset,
    output logic [OUTPUTS-1:0] reset_n,
    output logic               ready
`ifdef LOGIC_RESET_SEQUENCER_COUNTER_EN
    ,
    output logic [15:0]        reset_count
`endif
);

    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int STEP_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam int IDX_W  = (OUTPUTS > 1) ? $clog2(OUTPUTS) : 1;

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_CYCLES - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(OUTPUTS - 1);

    localparam logic [1:0] ST_HOLD    = 2'd0;
    localparam logic [1:0] ST_RELEASE = 2'd1;
    localparam logic [1:0] ST_RUN     = 2'd2;

    // Parameter sanity: a single flop is not a synchronizer, and zero-length
    // hold/step or zero domains make the sequence meaningless.
    generate
        if (STAGES < 2) begin : g_bad_stages
            $error("logic_reset_sequencer: STAGES must be >= 2");
        end
        if (OUTPUTS < 1) begin : g_bad_outputs
            $error("logic_reset_sequencer: OUTPUTS must be >= 1");
        end
        if (HOLD_CYCLES < 1 || STEP_CYCLES < 1) begin : g_bad_cycles
            $error("logic_reset_sequencer: HOLD_CYCLES and STEP_CYCLES must be >= 1");
        end
    endgenerate

    logic [RESETS-1:0]  sync_q [STAGES];
    logic [RESETS-1:0]  sync_d [STAGES];
    logic [1:0]         state_q, state_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic [STEP_W-1:0]  step_q, step_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [OUTPUTS-1:0] rst_n_q, rst_n_d;
    logic               ready_q, ready_d;
    logic               req;

    // Synchronizer chain: each request bit shifts one stage per clock.
    always_comb begin
        sync_d[0] = reset_request_n;
        for (int s = 1; s < STAGES; s++) begin
            sync_d[s] = sync_q[s-1];
        end
    end

    // Synchronizer flops; areset preloads "request asserted" so the domains
    // stay in reset until the chain has been flushed with real input values.
    always_ff @(posedge aclk) begin
        for (int s = 0; s < STAGES; s++) begin
            if (areset) begin
                sync_q[s] <= '0;
            end else begin
                sync_q[s] <= sync_d[s];
            end
        end
    end

    // Soft reset bypasses the synchronizer: it is already in the aclk domain.
    assign req = (~&sync_q[STAGES-1]) | soft_reset;

    // Sequencer next-state: hold, staged release, run; any request aborts to HOLD.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        step_d  = step_q;
        idx_d   = idx_q;
        rst_n_d = rst_n_q;
        ready_d = ready_q;
        case (state_q)
            ST_HOLD: begin
                rst_n_d = '0;
                ready_d = 1'b0;
                if (req) begin
                    hold_d = '0;
                end else if (hold_q == HOLD_LAST) begin
                    state_d = ST_RELEASE;
                    hold_d  = '0;
                    step_d  = '0;
                    idx_d   = '0;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            ST_RELEASE: begin
                if (req) begin
                    state_d = ST_HOLD;
                    rst_n_d = '0;
                    ready_d = 1'b0;
                    hold_d  = '0;
                    step_d  = '0;
                    idx_d   = '0;
                end else if (step_q == STEP_LAST) begin
                    step_d = '0;
                    // Only ever sets bits, so released domains stay released.
                    for (int k = 0; k < OUTPUTS; k++) begin
                        if (idx_q == IDX_W'(k)) begin
                            rst_n_d[k] = 1'b1;
                        end
                    end
                    if (idx_q == IDX_LAST) begin
                        state_d = ST_RUN;
                        ready_d = 1'b1;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    step_d = step_q + STEP_W'(1);
                end
            end
            ST_RUN: begin
                rst_n_d = '1;
                ready_d = 1'b1;
                if (req) begin
                    state_d = ST_HOLD;
                    rst_n_d = '0;
                    ready_d = 1'b0;
                    hold_d  = '0;
                    step_d  = '0;
                    idx_d   = '0;
                end
            end
            default: begin
                state_d = ST_HOLD;
                rst_n_d = '0;
                ready_d = 1'b0;
                hold_d  = '0;
                step_d  = '0;
                idx_d   = '0;
            end
        endcase
    end

    // Sequencer state registers; areset overrides everything.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q <= ST_HOLD;
            hold_q  <= '0;
            step_q  <= '0;
            idx_q   <= '0;
            rst_n_q <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            step_q  <= step_d;
            idx_q   <= idx_d;
            rst_n_q <= rst_n_d;
            ready_q <= ready_d;
        end
    end

    assign reset_n = rst_n_q;
    assign ready   = ready_q;

`ifdef LOGIC_RESET_SEQUENCER_COUNTER_EN
    logic [15:0] count_q, count_d;
    logic        to_hold;

    // A return to HOLD is a request seen while releasing or running;
    // areset-driven entry into HOLD is deliberately not counted.
    assign to_hold = req && ((state_q == ST_RELEASE) || (state_q == ST_RUN));

    // Saturating event count.
    always_comb begin
        count_d = count_q;
        if (to_hold && (count_q != 16'hFFFF)) begin
            count_d = count_q + 16'd1;
        end
    end

    // Event counter register, cleared only by areset.
    always_ff @(posedge aclk) begin
        if (areset) begin
            count_q <= 16'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign reset_count = count_q;
`endif

endmodule

// File: tb/tb_logic_reset_sequencer.sv
// Testbench for logic_reset_sequencer (STAGES=2, HOLD_CYCLES=4, STEP_CYCLES=2,
// OUTPUTS=3, RESETS=2). Expected outputs per edge come from the release timing
// formula and are queued before each edge, then popped and compared after it.
// The counter scenario is built only with LOGIC_RESET_SEQUENCER_COUNTER_EN.
module tb_logic_reset_sequencer;

    localparam int T0_PWR = 5;  // RELEASE entry edge after power-up (2 sync + 4 hold - 1)

    logic       aclk;
    logic       areset;
    logic [1:0] reset_request_n;
    logic       soft_reset;
    logic [2:0] reset_n;
    logic       ready;
`ifdef LOGIC_RESET_SEQUENCER_COUNTER_EN
    logic [15:0] reset_count;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct {
        logic [2:0] rn;
        logic       rdy;
    } exp_t;

    exp_t sb_q[$];
    exp_t e;

    logic_reset_sequencer #(
        .RESETS      (2),
        .OUTPUTS     (3),
        .STAGES      (2),
        .HOLD_CYCLES (4),
        .STEP_CYCLES (2)
    ) dut (
        .aclk            (aclk),
        .areset          (areset),
        .reset_request_n (reset_request_n),
        .soft_reset      (soft_reset),
        .reset_n         (reset_n),
        .ready           (ready)
`ifdef LOGIC_RESET_SEQUENCER_COUNTER_EN
        ,
        .reset_count     (reset_count)
`endif
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // Expected reset_n after edge i when RELEASE was entered at edge t0:
    // bit k rises at t0 + 2*(k+1).
    function automatic logic [2:0] exp_rn(int i, int t0);
        logic [2:0] r;
        for (int k = 0; k < 3; k++) r[k] = (i >= t0 + 2 * (k + 1));
        return r;
    endfunction

    function automatic logic exp_rdy(int i, int t0);
        return (i >= t0 + 6);
    endfunction

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic do_areset();
        areset          = 1'b1;
        reset_request_n = 2'b11;
        soft_reset      = 1'b0;
        repeat (3) tick();
        areset = 1'b0;
    endtask

    task automatic test_reset();
        areset          = 1'b1;
        reset_request_n = 2'b11;
        soft_reset      = 1'b0;
        repeat (3) tick();
        tests_run++;
        if (reset_n !== 3'b000 || ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_state: reset_n=%b ready=%b required reset_n=000 ready=0", reset_n, ready);
        end
`ifdef LOGIC_RESET_SEQUENCER_COUNTER_EN
        tests_run++;
        if (reset_count !== 16'd0) begin
            tests_failed++;
            $display("FAIL reset_count_init: got %h required 0000", reset_count);
        end
`endif
        areset = 1'b0;
    endtask

    task automatic test_power_up();
        for (int i = 0; i <= 13; i++) begin
            sb_q.push_back('{exp_rn(i, T0_PWR), exp_rdy(i, T0_PWR)});
            tick();
            e = sb_q.pop_front();
            tests_run++;
            if (reset_n !== e.rn || ready !== e.rdy) begin
                tests_failed++;
                $display("FAIL power_up F%0d: reset_n=%b ready=%b required reset_n=%b ready=%b",
                         i, reset_n, ready, e.rn, e.rdy);
            end
        end
    endtask

    task automatic test_hold_restart();
        do_areset();
        for (int i = 0; i <= 16; i++) begin
            soft_reset = (i == 5);   // after 3 request-free edges F2..F4
            sb_q.push_back('{exp_rn(i, 9), exp_rdy(i, 9)});
            tick();
            e = sb_q.pop_front();
            tests_run++;
            if (reset_n !== e.rn || ready !== e.rdy) begin
                tests_failed++;
                $display("FAIL hold_restart F%0d: reset_n=%b ready=%b required reset_n=%b ready=%b",
                         i, reset_n, ready, e.rn, e.rdy);
            end
        end
        soft_reset = 1'b0;
    endtask

    task automatic test_mid_release_abort();
        do_areset();
        for (int i = 0; i <= 21; i++) begin
            // reset_n becomes 001 at F7; request pulse sampled at F8 only
            reset_request_n = (i == 8) ? 2'b01 : 2'b11;
            if (i < 10) sb_q.push_back('{exp_rn(i, T0_PWR), exp_rdy(i, T0_PWR)});
            else        sb_q.push_back('{exp_rn(i, 14), exp_rdy(i, 14)});
            tick();
            e = sb_q.pop_front();
            tests_run++;
            if (reset_n !== e.rn || ready !== e.rdy) begin
                tests_failed++;
                $display("FAIL mid_release_abort F%0d: reset_n=%b ready=%b required reset_n=%b ready=%b",
                         i, reset_n, ready, e.rn, e.rdy);
            end
        end
        reset_request_n = 2'b11;
    endtask

    task automatic test_run_reassert();
        do_areset();
        for (int i = 0; i <= 24; i++) begin
            soft_reset = (i == 13);  // RUN since F11
            if (i < 13) sb_q.push_back('{exp_rn(i, T0_PWR), exp_rdy(i, T0_PWR)});
            else        sb_q.push_back('{exp_rn(i, 17), exp_rdy(i, 17)});
            tick();
            e = sb_q.pop_front();
            tests_run++;
            if (reset_n !== e.rn || ready !== e.rdy) begin
                tests_failed++;
                $display("FAIL run_reassert F%0d: reset_n=%b ready=%b required reset_n=%b ready=%b",
                         i, reset_n, ready, e.rn, e.rdy);
            end
        end
        soft_reset = 1'b0;
    endtask

    task automatic test_areset_priority();
        do_areset();
        for (int i = 0; i <= 25; i++) begin
            areset = (i == 11);      // coincides with the final release edge
            if (i < 11)       sb_q.push_back('{exp_rn(i, T0_PWR), exp_rdy(i, T0_PWR)});
            else if (i == 11) sb_q.push_back('{3'b000, 1'b0});
            else              sb_q.push_back('{exp_rn(i - 12, T0_PWR), exp_rdy(i - 12, T0_PWR)});
            tick();
            e = sb_q.pop_front();
            tests_run++;
            if (reset_n !== e.rn || ready !== e.rdy) begin
                tests_failed++;
                $display("FAIL areset_priority F%0d: reset_n=%b ready=%b required reset_n=%b ready=%b",
                         i, reset_n, ready, e.rn, e.rdy);
            end
        end
        areset = 1'b0;
    endtask

`ifdef LOGIC_RESET_SEQUENCER_COUNTER_EN
    task automatic test_counter();
        do_areset();
        repeat (12) tick();
        for (int ev = 1; ev <= 3; ev++) begin
            soft_reset = 1'b1;
            tick();
            soft_reset = 1'b0;
            tests_run++;
            if (reset_count !== 16'(ev)) begin
                tests_failed++;
                $display("FAIL counter_event%0d: got %0d required %0d", ev, reset_count, ev);
            end
            repeat (11) tick();
            tests_run++;
            if (ready !== 1'b1) begin
                tests_failed++;
                $display("FAIL counter_rerun%0d: ready=%b required 1", ev, ready);
            end
        end
        // Request inside HOLD is not a return to HOLD.
        soft_reset = 1'b1;
        tick();
        tick();
        soft_reset = 1'b0;
        tests_run++;
        if (reset_count !== 16'd4) begin
            tests_failed++;
            $display("FAIL counter_hold_req: got %0d required 4", reset_count);
        end
        repeat (12) tick();
        areset = 1'b1;
        tick();
        areset = 1'b0;
        tests_run++;
        if (reset_count !== 16'd0) begin
            tests_failed++;
            $display("FAIL counter_areset: got %0d required 0", reset_count);
        end
        repeat (12) tick();
        tests_run++;
        if (reset_count !== 16'd0 || ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL counter_after_areset: count=%0d ready=%b required count=0 ready=1",
                     reset_count, ready);
        end
        force dut.count_q = 16'hFFFE;
        #1;
        release dut.count_q;
        for (int ev = 1; ev <= 2; ev++) begin
            soft_reset = 1'b1;
            tick();
            soft_reset = 1'b0;
            tests_run++;
            if (reset_count !== 16'hFFFF) begin
                tests_failed++;
                $display("FAIL counter_saturate%0d: got %h required FFFF", ev, reset_count);
            end
            repeat (11) tick();
        end
    endtask
`endif

    initial begin
        areset          = 1'b1;
        reset_request_n = 2'b11;
        soft_reset      = 1'b0;
        test_reset();
        test_power_up();
        test_hold_restart();
        test_mid_release_abort();
        test_run_reassert();
        test_areset_priority();
`ifdef LOGIC_RESET_SEQUENCER_COUNTER_EN
        test_counter();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
